// File: rtl/sb_deser_frame_ctrl.sv
// Sideband receive framing controller for the bus deserializer.
// It hunts the raw serial stream for the sync word and enables the
// deserializer on the bit that follows it. It then counts bit positions
// in lockstep with the deserializer, parses the length header, and forwards
// payload words through a single-register valid/ready output stage.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | receive disabled, everything parked
//   HUNT    | shifting serial_in through the shadow register, seeking sync
//   LEN     | deserializer running, waiting for the length word
//   PAYLOAD | deserializer running, forwarding len payload words
module sb_deser_frame_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = 8'hA5,
    parameter int                    MAX_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_en,
    input  logic                  serial_in,
    output logic                  deser_enable,
    input  logic [DATA_WIDTH-1:0] deser_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  err_len,
    output logic                  err_ovf,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
    localparam logic [DATA_WIDTH-1:0] ONE_W     = DATA_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, HUNT, LEN, PAYLOAD} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] sh;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  word_strobe;
    logic [DATA_WIDTH-1:0] len;
    logic [DATA_WIDTH-1:0] word_cnt;

    logic sync_hit;
    logic len_bad;
    logic last_word;
    logic load_word;

    assign sync_hit  = ({sh[DATA_WIDTH-2:0], serial_in} == SYNC_WORD);
    assign len_bad   = (deser_data == '0) || (deser_data > MAX_LEN_W);
    assign last_word = (word_cnt == (len - ONE_W));
    assign load_word = ctrl_en && (state == PAYLOAD) && word_strobe;

    // The deserializer runs exactly while a frame is being received, so
    // leaving LEN/PAYLOAD (or an async reset) stops it on the same edge and
    // it is cleared on the following one.
    assign busy         = (state == LEN) || (state == PAYLOAD);
    assign deser_enable = busy;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        if (!ctrl_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = HUNT;
                HUNT:    if (sync_hit) state_nxt = LEN;
                LEN:     if (word_strobe) state_nxt = len_bad ? HUNT : PAYLOAD;
                PAYLOAD: if (word_strobe && last_word) state_nxt = HUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shadow shifter, bit/word counters, header capture and output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh          <= '0;
            bit_cnt     <= '0;
            word_strobe <= 1'b0;
            len         <= '0;
            word_cnt    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_len    <= 1'b0;
            if (!ctrl_en) begin
                sh          <= '0;
                bit_cnt     <= '0;
                word_strobe <= 1'b0;
                word_cnt    <= '0;
                out_valid   <= 1'b0;
                out_last    <= 1'b0;
                err_ovf     <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        sh          <= {sh[DATA_WIDTH-2:0], serial_in};
                        bit_cnt     <= '0;
                        word_strobe <= 1'b0;
                    end
                    LEN, PAYLOAD: begin
                        // sh is held clear so the next hunt starts fresh and a
                        // sync pattern inside the payload is never seen.
                        sh          <= '0;
                        bit_cnt     <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_ONE;
                        word_strobe <= (bit_cnt == CNT_LAST);
                    end
                    default: begin
                        sh          <= '0;
                        bit_cnt     <= '0;
                        word_strobe <= 1'b0;
                    end
                endcase

                if ((state == LEN) && word_strobe) begin
                    len <= deser_data;
                    if (len_bad) err_len  <= 1'b1;
                    else         word_cnt <= '0;
                end

                // Single output register: the serial stream cannot stall, so a
                // word arriving while the previous one is still held replaces it.
                if (load_word) begin
                    out_data  <= deser_data;
                    out_valid <= 1'b1;
                    out_last  <= last_word;
                    word_cnt  <= word_cnt + ONE_W;
                    if (last_word) frame_done <= 1'b1;
                    if (out_valid && !out_ready) err_ovf <= 1'b1;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_deser_frame_ctrl.sv
// Bench for sb_deser_frame_ctrl: includes a behavioural model of the bus
// deserializer (MSB-first shift register, cleared while disabled).
module tb_sb_deser_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_en = 1'b0;
    logic       serial_in = 1'b0;
    logic       deser_enable;
    logic [7:0] deser_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       frame_done;
    logic       err_len;
    logic       err_ovf;
    logic       busy;

    int total = 0;
    int bad   = 0;

    sb_deser_frame_ctrl #(.DATA_WIDTH(8), .SYNC_WORD(8'hA5), .MAX_LEN(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_en      (ctrl_en),
        .serial_in    (serial_in),
        .deser_enable (deser_enable),
        .deser_data   (deser_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .frame_done   (frame_done),
        .err_len      (err_len),
        .err_ovf      (err_ovf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Deserializer model.
    logic [7:0] deser_sr = 8'h00;
    always_ff @(posedge clk) begin
        if (deser_enable) deser_sr <= {deser_sr[6:0], serial_in};
        else              deser_sr <= 8'h00;
    end
    assign deser_data = deser_sr;

    // Monitor: accepted words, pulse counts.
    logic [8:0] q[$];
    int n_done = 0;
    int n_err  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) q.push_back({out_last, out_data});
            if (frame_done) n_done = n_done + 1;
            if (err_len)    n_err  = n_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    typedef struct packed {
        logic [7:0]   len_byte;
        logic [4:0]   nw;
        logic [127:0] pl;
        logic [4:0]   exp_words;
        logic         exp_err;
    } frame_t;

    localparam int NF = 7;
    frame_t tbl[NF];

    function automatic frame_t mk(input logic [7:0] l, input logic [4:0] nw,
                                  input logic [127:0] pl, input logic [4:0] ew,
                                  input logic ee);
        frame_t r;
        r.len_byte  = l;
        r.nw        = nw;
        r.pl        = pl;
        r.exp_words = ew;
        r.exp_err   = ee;
        return r;
    endfunction

    initial begin
        frame_t       rec;
        logic [127:0] pl;
        logic [127:0] pl16;
        logic [2:0]   rbits;
        logic [8:0]   w;

        pl16 = '0;
        for (int i = 0; i < 16; i++) pl16[8*i +: 8] = 8'(i * 17 + 3);

        // word 0 in the low byte
        tbl[0] = mk(8'h02, 5'd2,  128'hC33C, 5'd2,  1'b0);
        tbl[1] = mk(8'h00, 5'd0,  128'h0,    5'd0,  1'b1);
        tbl[2] = mk(8'h11, 5'd0,  128'h0,    5'd0,  1'b1);
        tbl[3] = mk(8'h01, 5'd1,  128'h55,   5'd1,  1'b0);
        tbl[4] = mk(8'h02, 5'd2,  128'h77A5, 5'd2,  1'b0);
        tbl[5] = mk(8'h10, 5'd16, pl16,      5'd16, 1'b0);
        tbl[6] = mk(8'hFF, 5'd0,  128'h0,    5'd0,  1'b1);

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", {deser_enable, out_valid, out_last, frame_done,
                             err_len, err_ovf, busy, out_data}, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            serial_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_outs", {deser_enable, out_valid, out_last, frame_done,
                                err_len, err_ovf, busy, out_data}, 0);
        end

        // Frame table
        ctrl_en = 1'b1;
        rbits = 3'($urandom_range(0, 7)) & 3'b011;
        for (int i = 2; i >= 0; i--) send_bit(rbits[i]);
        for (int f = 0; f < NF; f++) begin
            rec = tbl[f];
            pl  = rec.pl;
            n_done = 0;
            n_err  = 0;
            q.delete();
            repeat (2) send_bit(1'b0);
            send_byte(SYNC);
            send_byte(rec.len_byte);
            for (int i = 0; i < int'(rec.nw); i++) send_byte(pl[8*i +: 8]);
            repeat (4) send_bit(1'b0);
            check("err_len_count", n_err, 32'(rec.exp_err));
            check("frame_done_count", n_done, (rec.exp_words != 0) ? 1 : 0);
            check("word_count", q.size(), 32'(rec.exp_words));
            for (int i = 0; i < q.size() && i < int'(rec.exp_words); i++) begin
                w = q[i];
                check("word_data", w[7:0], pl[8*i +: 8]);
                check("word_last", w[8], (i == int'(rec.exp_words) - 1) ? 1 : 0);
            end
            check("no_ovf", err_ovf, 0);
            check("back_to_hunt", busy, 0);
        end

        // Latency: last bit at t -> out_valid at t+2, frame_done alongside
        repeat (2) send_bit(1'b0);
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h6B);
        check("lat_valid_early", out_valid, 0);
        check("lat_enable_early", deser_enable, 1);
        send_bit(1'b0);
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 8'h6B);
        check("lat_last", out_last, 1);
        check("lat_done", frame_done, 1);
        check("lat_enable_off", deser_enable, 0);
        repeat (3) send_bit(1'b0);

        // Backpressure / overflow
        out_ready = 1'b0;
        repeat (2) send_bit(1'b0);
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovf_before", err_ovf, 0);
        check("ovf_hold0", out_data, 8'h11);
        send_byte(8'h33);
        check("ovf_set", err_ovf, 1);
        check("ovf_data1", out_data, 8'h22);
        send_bit(1'b0);
        repeat (3) send_bit(1'b0);
        check("ovf_valid_held", out_valid, 1);
        check("ovf_data2", out_data, 8'h33);
        check("ovf_last", out_last, 1);
        check("ovf_sticky", err_ovf, 1);
        ctrl_en = 1'b0;
        @(negedge clk);
        check("ovf_clear", err_ovf, 0);
        check("valid_clear", out_valid, 0);
        out_ready = 1'b1;
        ctrl_en   = 1'b1;

        // Reset mid-frame
        repeat (2) send_bit(1'b0);
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h4D);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        check("midrst_enable_pre", deser_enable, 1);
        rst = 1'b1;
        #1;
        check("midrst_enable", deser_enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        n_done = 0;
        n_err  = 0;
        repeat (2) send_bit(1'b0);
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h9E);
        repeat (4) send_bit(1'b0);
        check("midrst_count", q.size(), 1);
        if (q.size() > 0) check("midrst_word", q[0], {1'b1, 8'h9E});
        check("midrst_done", n_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
